spi_sfr_arb: RTL and testbench
==============================

SPI_SFR_ARB -- requirements
Module: spi_sfr_arb

Interface
REQ-001 SHALL have ports, listed as name, direction, width, meaning:
- clk, in, 1, clock
- rst, in, 1, reset, asynchronous, active-low
REQ-002 SHALL have host-side ports:
- h_req, in, 1, host access request
- h_we, in, 1, 1 = write, 0 = read
- h_addr, in, 3, SFR address
- h_wdata, in, 8, write data
- h_lock, in, 1, hold exclusive host ownership
REQ-003 SHALL have host response ports:
- h_ack, out, 1, one-cycle completion pulse
- h_rdata, out, 8, read data, valid with h_ack
- h_err, out, 1, illegal-address flag, valid with h_ack
REQ-004 SHALL have SPI-core ports:
- s_req, s_we, s_addr[2:0], s_wdata[7:0], in, same meanings as the host ports
- s_ack, s_rdata[7:0], s_err, out, same meanings as the host ports
REQ-005 SHALL have SFR-port ports:
- sfrwe, out, 1, SFR write enable
- sfraddr_w, out, 3, SFR write address
- sfraddr_r, out, 3, SFR read address
- sfrdatai, out, 8, SFR write data
- sfrdatao, in, 8, SFR read data (combinational from sfraddr_r)

Function
REQ-006 SHALL run FSM IDLE -> ACC -> RESP -> IDLE; each state lasts exactly one cycle except IDLE, which waits for an eligible request.
REQ-007 In IDLE with at least one eligible request, SHALL pick a winner and latch its we, addr and wdata at that clock edge, then enter ACC.
REQ-008 In ACC, for a legal write (addr 0-5), SHALL drive sfrwe=1 with sfraddr_w and sfrdatai from the latch; sfrwe SHALL be 0 in every other state.
REQ-009 In ACC, for a legal read, SHALL drive sfraddr_r from the latch and register sfrdatao into the winner's rdata at the end of ACC.
REQ-010 In RESP, SHALL assert the winner's ack for exactly one cycle, with rdata and err valid; ack SHALL never be asserted to both requesters in the same cycle.
REQ-011 Access latency, from the edge where a request is sampled to ack high, SHALL be 2 cycles; maximum throughput SHALL be one access per 3 cycles.
REQ-012 Requesters SHALL hold req and payload stable until ack; the requester just served SHALL be masked (ineligible) in the IDLE cycle directly after RESP.
REQ-013 Addr 6 or 7 SHALL produce no sfrwe, rdata=0 and err=1 with ack; err SHALL be 0 for legal addresses.
REQ-014 For a write ack, rdata SHALL be 0.
REQ-015 If h_lock=1 when a host access is acked, SHALL grant only the host until a host ack occurs with h_lock=0; s_req SHALL wait, and lock SHALL have no effect while the SPI core is being served.
REQ-016 sfraddr_r SHALL hold its last value outside ACC, with reset value 0.

Reset
REQ-017 While rst=0, SHALL hold: FSM=IDLE, sfrwe=0, sfraddr_w=0, sfraddr_r=0, sfrdatai=0, both acks=0, both errs=0, both rdata=0, lock released, round-robin pointer = host-preferred.
REQ-018 Reset asserted in ACC or RESP SHALL abort the access with no ack issued; a write aborted in ACC MAY have already reached the SFR.

Configuration
REQ-019 Macro SFR_ARB_RR_EN defined: round-robin arbitration; the pointer flips to the other requester after each ack, and on a simultaneous request the pointer's requester wins.
REQ-020 SFR_ARB_RR_EN undefined: fixed priority, SPI core over host; h_lock still honoured.

Verification
REQ-021 Host write addr 2, data 0x5A -> sfrwe=1 with sfraddr_w=2 and sfrdatai=0x5A one cycle after sampling; h_ack the next cycle; h_err=0.
REQ-022 Host read addr 4 with sfrdatao=0xC3 in ACC -> h_ack 2 cycles after sampling, h_rdata=0xC3.
REQ-023 h_req and s_req asserted together from reset, both held -> RR build: host acked first, then SPI core; fixed build: SPI core acked first, then host.
REQ-024 Host write addr 7 -> no sfrwe, h_ack with h_err=1 and h_rdata=0.
REQ-025 Host three reads with h_lock=1 on the first two, s_req held throughout -> s_ack only after the third h_ack.
REQ-026 rst pulsed low during ACC -> no h_ack, all outputs 0, FSM returns to IDLE and serves the next request normally.

Source files
------------

// File: rtl/spi_sfr_arb.sv
// Two-requester (host / SPI core) arbiter onto a single SFR port, with host lock.
// Define SFR_ARB_RR_EN for round-robin arbitration; default is fixed priority, SPI core first.

module spi_sfr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       h_req,
  input  logic       h_we,
  input  logic [2:0] h_addr,
  input  logic [7:0] h_wdata,
  input  logic       h_lock,
  output logic       h_ack,
  output logic [7:0] h_rdata,
  output logic       h_err,
  input  logic       s_req,
  input  logic       s_we,
  input  logic [2:0] s_addr,
  input  logic [7:0] s_wdata,
  output logic       s_ack,
  output logic [7:0] s_rdata,
  output logic       s_err,
  output logic       sfrwe,
  output logic [2:0] sfraddr_w,
  output logic [2:0] sfraddr_r,
  output logic [7:0] sfrdatai,
  input  logic [7:0] sfrdatao
);

  // state | meaning
  // IDLE  | wait for an eligible request, latch the winner's payload
  // ACC   | drive the SFR port for one cycle, capture read data
  // RESP  | one-cycle ack to the winner with rdata/err
  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t     state, state_nx;
  logic       win_s;
  logic       lat_we;
  logic [2:0] lat_addr;
  logic [7:0] lat_wdata;
  logic [7:0] rdata_q;
  logic       err_q;
  logic       lock_q;
  logic       mask_h, mask_s;
  logic [2:0] raddr_q;
  logic       elig_h, elig_s, grant, pick_s;
  logic       sel_we;
  logic [2:0] sel_addr;
  logic [7:0] sel_wdata;
  logic       lat_legal, sel_legal;
`ifdef SFR_ARB_RR_EN
  logic       ptr_q;
`endif

  function automatic logic legal(input logic [2:0] a);
    return !(a[2] & a[1]);
  endfunction

  // A held lock shuts the SPI core out; the requester just served sits out one IDLE cycle.
  assign elig_h = h_req & ~mask_h;
  assign elig_s = s_req & ~mask_s & ~lock_q;
  assign grant  = elig_h | elig_s;

`ifdef SFR_ARB_RR_EN
  assign pick_s = elig_s & (~elig_h | ptr_q);
`else
  assign pick_s = elig_s;
`endif

  assign sel_we    = pick_s ? s_we    : h_we;
  assign sel_addr  = pick_s ? s_addr  : h_addr;
  assign sel_wdata = pick_s ? s_wdata : h_wdata;
  assign sel_legal = legal(sel_addr);
  assign lat_legal = legal(lat_addr);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = ACC;
      ACC:     state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      win_s     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 3'd0;
      lat_wdata <= 8'd0;
      rdata_q   <= 8'd0;
      err_q     <= 1'b0;
      lock_q    <= 1'b0;
      mask_h    <= 1'b0;
      mask_s    <= 1'b0;
      raddr_q   <= 3'd0;
`ifdef SFR_ARB_RR_EN
      ptr_q     <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      mask_h <= 1'b0;
      mask_s <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            win_s     <= pick_s;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            if (!sel_we && sel_legal) raddr_q <= sel_addr;
          end
        end
        ACC: begin
          rdata_q <= (!lat_we && lat_legal) ? sfrdatao : 8'd0;
          err_q   <= ~lat_legal;
        end
        RESP: begin
          mask_h <= ~win_s;
          mask_s <= win_s;
          if (!win_s) lock_q <= h_lock;
`ifdef SFR_ARB_RR_EN
          ptr_q  <= ~win_s;
`endif
        end
        default: ;
      endcase
    end
  end

  assign sfrwe     = (state == ACC) & lat_we & lat_legal;
  assign sfraddr_w = lat_addr;
  assign sfrdatai  = lat_wdata;
  assign sfraddr_r = raddr_q;

  assign h_ack   = (state == RESP) & ~win_s;
  assign s_ack   = (state == RESP) &  win_s;
  assign h_rdata = h_ack ? rdata_q : 8'd0;
  assign s_rdata = s_ack ? rdata_q : 8'd0;
  assign h_err   = h_ack & err_q;
  assign s_err   = s_ack & err_q;

endmodule

// File: tb/tb_spi_sfr_arb.sv
// Self-checking bench for spi_sfr_arb: directed scenarios plus randomized two-requester traffic
// against a transaction-level SFR memory model.

module tb_spi_sfr_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       h_req, h_we, h_lock;
  logic [2:0] h_addr;
  logic [7:0] h_wdata;
  logic       h_ack, h_err;
  logic [7:0] h_rdata;
  logic       s_req, s_we;
  logic [2:0] s_addr;
  logic [7:0] s_wdata;
  logic       s_ack, s_err;
  logic [7:0] s_rdata;
  logic       sfrwe;
  logic [2:0] sfraddr_w, sfraddr_r;
  logic [7:0] sfrdatai, sfrdatao;

  int errs = 0;
  int checks = 0;

`ifdef SFR_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // SFR file seen by the DUT, and the value each address should hold after acked writes.
  logic [7:0] sfr    [0:7] = '{default: 8'd0};
  logic [7:0] refmem [0:7] = '{default: 8'd0};
  assign sfrdatao = sfr[sfraddr_r];
  always @(posedge clk) if (sfrwe) sfr[sfraddr_w] <= sfrdatai;

  logic mon_en = 1'b0;
  logic locked = 1'b0;

  spi_sfr_arb dut (
    .clk(clk), .rst(rst),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_lock(h_lock),
    .h_ack(h_ack), .h_rdata(h_rdata), .h_err(h_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata), .s_err(s_err),
    .sfrwe(sfrwe), .sfraddr_w(sfraddr_w), .sfraddr_r(sfraddr_r),
    .sfrdatai(sfrdatai), .sfrdatao(sfrdatao)
  );

  initial forever #5 clk = ~clk;

  // Lock rule: after a host ack with h_lock=1, no SPI ack until a host ack with h_lock=0.
  always @(negedge clk) begin
    if (mon_en && (h_ack || s_ack)) begin
      checks++;
      if (h_ack && s_ack) begin errs++; $display("FAIL dual_ack: h_ack=1 s_ack=1, required at most one"); end
      if (s_ack && locked) begin errs++; $display("FAIL lock_block: s_ack=1 while host lock held, required 0"); end
      if (h_ack) locked = h_lock;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_xfer(input logic we, input logic [2:0] a, input logic [7:0] d, input logic lk,
                           output logic [7:0] rd, output logic er, output int lat);
    h_we = we; h_addr = a; h_wdata = d; h_lock = lk; h_req = 1'b1;
    lat = -1; rd = 8'd0; er = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (h_ack) begin lat = i; rd = h_rdata; er = h_err; break; end
    end
    h_req = 1'b0;
  endtask

  task automatic spi_xfer(input logic we, input logic [2:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic er, output int lat);
    s_we = we; s_addr = a; s_wdata = d; s_req = 1'b1;
    lat = -1; rd = 8'd0; er = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (s_ack) begin lat = i; rd = s_rdata; er = s_err; break; end
    end
    s_req = 1'b0;
  endtask

  // Both requesters raise req together; who = 0 host, 1 SPI, -1 none.
  task automatic race(output int first, output int t1, output int second, output int t2);
    logic hd, sd;
    first = -1; second = -1; t1 = -1; t2 = -1; hd = 0; sd = 0;
    h_we = 0; h_addr = 3'd0; h_lock = 0; s_we = 0; s_addr = 3'd1;
    h_req = 1'b1; s_req = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (h_ack && !hd) begin
        hd = 1; h_req = 1'b0;
        if (first < 0) begin first = 0; t1 = i; end else begin second = 0; t2 = i; end
      end
      if (s_ack && !sd) begin
        sd = 1; s_req = 1'b0;
        if (first < 0) begin first = 1; t1 = i; end else begin second = 1; t2 = i; end
      end
      if (hd && sd) break;
    end
    h_req = 1'b0; s_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0; h_lock = 0;
    s_req = 0; s_we = 0; s_addr = 0; s_wdata = 0;
    idle(3);
    checks++; if ({h_ack, s_ack} !== 2'b00) begin errs++; $display("FAIL rst_ack: got %b, required 00", {h_ack, s_ack}); end
    checks++; if ({h_err, s_err} !== 2'b00) begin errs++; $display("FAIL rst_err: got %b, required 00", {h_err, s_err}); end
    checks++; if ({h_rdata, s_rdata} !== 16'h0) begin errs++; $display("FAIL rst_rdata: got %h, required 0000", {h_rdata, s_rdata}); end
    checks++; if (sfrwe !== 1'b0) begin errs++; $display("FAIL rst_sfrwe: got %b, required 0", sfrwe); end
    checks++; if ({sfraddr_w, sfraddr_r, sfrdatai} !== 14'h0) begin errs++; $display("FAIL rst_sfrport: got w=%0d r=%0d d=%h, required 0", sfraddr_w, sfraddr_r, sfrdatai); end
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_write();
    idle(2);
    h_we = 1; h_addr = 3'd2; h_wdata = 8'h5A; h_lock = 0; h_req = 1;
    @(negedge clk);
    checks++; if ({sfrwe, sfraddr_w, sfrdatai} !== {1'b1, 3'd2, 8'h5A}) begin errs++; $display("FAIL wr_acc: got we=%b a=%0d d=%h, required we=1 a=2 d=5a", sfrwe, sfraddr_w, sfrdatai); end
    checks++; if (h_ack !== 1'b0) begin errs++; $display("FAIL wr_early_ack: got %b, required 0", h_ack); end
    @(negedge clk);
    checks++; if ({h_ack, h_err, h_rdata} !== {1'b1, 1'b0, 8'h00}) begin errs++; $display("FAIL wr_resp: got ack=%b err=%b rd=%h, required 1 0 00", h_ack, h_err, h_rdata); end
    checks++; if (sfrwe !== 1'b0) begin errs++; $display("FAIL wr_sfrwe_resp: got %b, required 0", sfrwe); end
    h_req = 0; refmem[2] = 8'h5A;
    @(negedge clk);
    checks++; if (h_ack !== 1'b0) begin errs++; $display("FAIL wr_ack_pulse: got %b, required 0", h_ack); end
  endtask

  task automatic test_read();
    logic [7:0] rd; logic er; int lat;
    idle(2);
    host_xfer(1, 3'd4, 8'hC3, 0, rd, er, lat);
    refmem[4] = 8'hC3;
    checks++; if (lat !== 2) begin errs++; $display("FAIL wr4_latency: got %0d, required 2", lat); end
    idle(2);
    h_we = 0; h_addr = 3'd4; h_req = 1;
    @(negedge clk);
    checks++; if ({sfrwe, sfraddr_r} !== {1'b0, 3'd4}) begin errs++; $display("FAIL rd_acc: got we=%b ra=%0d, required we=0 ra=4", sfrwe, sfraddr_r); end
    @(negedge clk);
    checks++; if ({h_ack, h_err, h_rdata} !== {1'b1, 1'b0, 8'hC3}) begin errs++; $display("FAIL rd_resp: got ack=%b err=%b rd=%h, required 1 0 c3", h_ack, h_err, h_rdata); end
    h_req = 0;
    idle(2);
    checks++; if (sfraddr_r !== 3'd4) begin errs++; $display("FAIL rd_addr_hold: got %0d, required 4", sfraddr_r); end
  endtask

  task automatic test_illegal();
    logic [7:0] rd; logic er; int lat;
    idle(2);
    h_we = 1; h_addr = 3'd7; h_wdata = 8'hFF; h_req = 1;
    @(negedge clk);
    checks++; if (sfrwe !== 1'b0) begin errs++; $display("FAIL ill_sfrwe: got %b, required 0", sfrwe); end
    @(negedge clk);
    checks++; if ({h_ack, h_err, h_rdata} !== {1'b1, 1'b1, 8'h00}) begin errs++; $display("FAIL ill_resp: got ack=%b err=%b rd=%h, required 1 1 00", h_ack, h_err, h_rdata); end
    h_req = 0;
    idle(2);
    spi_xfer(0, 3'd6, 8'h00, rd, er, lat);
    checks++; if ({lat[3:0], er, rd} !== {4'd2, 1'b1, 8'h00}) begin errs++; $display("FAIL ill_spi_rd: got lat=%0d err=%b rd=%h, required 2 1 00", lat, er, rd); end
    checks++; if (sfraddr_r !== 3'd4) begin errs++; $display("FAIL ill_raddr_hold: got %0d, required 4", sfraddr_r); end
    idle(2);
    spi_xfer(0, 3'd2, 8'h00, rd, er, lat);
    checks++; if ({er, rd} !== {1'b0, refmem[2]}) begin errs++; $display("FAIL spi_rd2: got err=%b rd=%h, required 0 %h", er, rd, refmem[2]); end
  endtask

  task automatic test_simul();
    int f, t1, s, t2;
    test_reset();
    race(f, t1, s, t2);
    checks++; if (f !== (RR ? 0 : 1)) begin errs++; $display("FAIL simul_first: got %0d, required %0d", f, RR ? 0 : 1); end
    checks++; if (s !== (RR ? 1 : 0)) begin errs++; $display("FAIL simul_second: got %0d, required %0d", s, RR ? 1 : 0); end
    checks++; if (t1 !== 2) begin errs++; $display("FAIL simul_latency: got %0d, required 2", t1); end
    checks++; if (t2 - t1 !== 3) begin errs++; $display("FAIL simul_spacing: got %0d, required 3", t2 - t1); end
  endtask

  task automatic test_rr_ptr();
    int f, t1, s, t2, lat; logic [7:0] rd; logic er;
    idle(2);
    spi_xfer(0, 3'd0, 8'h00, rd, er, lat);
    idle(2);
    race(f, t1, s, t2);
    checks++; if (f !== (RR ? 0 : 1)) begin errs++; $display("FAIL ptr_after_spi: got %0d, required %0d", f, RR ? 0 : 1); end
    idle(2);
    host_xfer(0, 3'd0, 8'h00, 0, rd, er, lat);
    idle(2);
    race(f, t1, s, t2);
    checks++; if (f !== 1) begin errs++; $display("FAIL ptr_after_host: got %0d, required 1", f); end
  endtask

  task automatic test_lock();
    int nh, th3, ts; logic early, pend;
    idle(2);
    nh = 0; th3 = -1; ts = -1; early = 0; pend = 0;
    h_we = 0; h_addr = 3'd0; h_lock = 1; h_req = 1;
    @(negedge clk);
    s_we = 0; s_addr = 3'd1; s_req = 1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (s_ack) begin
        if (nh < 3) early = 1;
        else begin ts = i; s_req = 0; end
      end
      if (h_ack) begin
        nh++;
        if (nh == 3) begin th3 = i; h_req = 0; end else pend = 1;
      end else if (pend) begin
        pend = 0; h_addr = nh[2:0]; h_lock = (nh < 2);
      end
      if (ts >= 0) break;
    end
    s_req = 0; h_req = 0; h_lock = 0;
    checks++; if (early !== 1'b0) begin errs++; $display("FAIL lock_early_sack: got 1, required 0"); end
    checks++; if (nh !== 3) begin errs++; $display("FAIL lock_host_acks: got %0d, required 3", nh); end
    checks++; if (ts - th3 !== 3 || ts < 0) begin errs++; $display("FAIL lock_release: s_ack %0d cycles after 3rd h_ack, required 3", ts - th3); end
  endtask

  task automatic test_abort();
    logic [7:0] rd; logic er; int lat; logic seen;
    idle(2);
    h_we = 1; h_addr = 3'd1; h_wdata = 8'h77; h_lock = 0; h_req = 1;
    @(negedge clk);
    checks++; if (sfrwe !== 1'b1) begin errs++; $display("FAIL abort_in_acc: sfrwe=%b, required 1", sfrwe); end
    rst = 0; h_req = 0;
    #1;
    checks++; if ({h_ack, s_ack, h_err, s_err, sfrwe, sfraddr_w, sfraddr_r, sfrdatai, h_rdata, s_rdata} !== 35'h0)
      begin errs++; $display("FAIL abort_outputs: got ack=%b%b we=%b wa=%0d ra=%0d d=%h, required all 0", h_ack, s_ack, sfrwe, sfraddr_w, sfraddr_r, sfrdatai); end
    seen = 0;
    repeat (3) begin @(negedge clk); if (h_ack) seen = 1; end
    rst = 1;
    @(negedge clk); if (h_ack) seen = 1;
    checks++; if (seen !== 1'b0) begin errs++; $display("FAIL abort_no_ack: h_ack seen, required none"); end
    host_xfer(0, 3'd2, 8'h00, 0, rd, er, lat);
    checks++; if (lat !== 2 || rd !== refmem[2] || er !== 1'b0) begin errs++; $display("FAIL abort_recover: got lat=%0d rd=%h err=%b, required 2 %h 0", lat, rd, er, refmem[2]); end
  endtask

  task automatic host_proc(input int n);
    logic we, lk; logic [2:0] a; logic [7:0] d, exp; int got;
    for (int k = 0; k < n; k++) begin
      idle($urandom_range(1, 3));
      we = 1'($urandom); a = 3'($urandom_range(0, 7)); d = 8'($urandom);
      lk = (k != n - 1) && ($urandom_range(0, 3) == 0);
      h_we = we; h_addr = a; h_wdata = d; h_lock = lk; h_req = 1;
      got = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (h_ack) begin got = 1; break; end
      end
      checks++;
      if (!got) begin errs++; $display("FAIL rnd_host_timeout: no h_ack in 200 cycles, required ack"); h_req = 0; break; end
      exp = (we || a >= 6) ? 8'h00 : refmem[a];
      if (h_rdata !== exp || h_err !== (a >= 6)) begin
        errs++; $display("FAIL rnd_host_resp: a=%0d we=%b got rd=%h err=%b, required rd=%h err=%b", a, we, h_rdata, h_err, exp, a >= 6);
      end
      if (we && a < 6) refmem[a] = d;
      h_req = 0;
    end
    h_lock = 0;
  endtask

  task automatic spi_proc(input int n);
    logic we; logic [2:0] a; logic [7:0] d, exp; int got;
    for (int k = 0; k < n; k++) begin
      idle($urandom_range(0, 3));
      we = 1'($urandom); a = 3'($urandom_range(0, 7)); d = 8'($urandom);
      s_we = we; s_addr = a; s_wdata = d; s_req = 1;
      got = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (s_ack) begin got = 1; break; end
      end
      checks++;
      if (!got) begin errs++; $display("FAIL rnd_spi_timeout: no s_ack in 200 cycles, required ack"); s_req = 0; break; end
      exp = (we || a >= 6) ? 8'h00 : refmem[a];
      if (s_rdata !== exp || s_err !== (a >= 6)) begin
        errs++; $display("FAIL rnd_spi_resp: a=%0d we=%b got rd=%h err=%b, required rd=%h err=%b", a, we, s_rdata, s_err, exp, a >= 6);
      end
      if (we && a < 6) refmem[a] = d;
      s_req = 0;
    end
  endtask

  task automatic test_random();
    logic [7:0] rd, d; logic er; int lat;
    for (int a = 0; a < 6; a++) begin
      idle(2);
      d = 8'($urandom);
      host_xfer(1, 3'(a), d, 0, rd, er, lat);
      refmem[a] = d;
      checks++; if (lat !== 2) begin errs++; $display("FAIL rnd_init_wr: a=%0d latency %0d, required 2", a, lat); end
    end
    idle(2);
    locked = 0; mon_en = 1;
    fork
      host_proc(40);
      spi_proc(40);
    join
    idle(2);
    mon_en = 0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_illegal();
    test_simul();
    test_rr_ptr();
    test_lock();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
